// File: rtl/bwu_pkg.sv
// bwu_pkg: opcodes and widths shared by the bitwise unit arbiter.
// The datapath width is fixed at 64 bits.
package bwu_pkg;

    localparam int DW = 64;

    localparam logic [2:0] BWU_AND  = 3'b000;
    localparam logic [2:0] BWU_OR   = 3'b001;
    localparam logic [2:0] BWU_XOR  = 3'b010;
    localparam logic [2:0] BWU_XNOR = 3'b011;
    localparam logic [2:0] BWU_NOT  = 3'b100;
    localparam logic [2:0] BWU_EQ   = 3'b101;

    typedef enum logic [2:0] {
        OP_AND  = BWU_AND,
        OP_OR   = BWU_OR,
        OP_XOR  = BWU_XOR,
        OP_XNOR = BWU_XNOR,
        OP_NOT  = BWU_NOT,
        OP_EQ   = BWU_EQ,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } bwu_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr.
// Emits a one-hot grant and its binary index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitwise_unit_arbiter.sv
// bitwise_unit_arbiter: NREQ requesters share one 2-stage 64-bit logic unit.
// Define BWU_PERF_CNT_EN to add saturating per-requester grant counters.
module bitwise_unit_arbiter
    import bwu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [DW*NREQ-1:0]   req_a,
    input  logic [DW*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_err
`ifdef BWU_PERF_CNT_EN
    ,
    output logic [32*NREQ-1:0]   grant_cnt
`endif
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic            adv1, adv2;
    logic            s1_valid, s2_valid;
    bwu_op_t         s1_op;
    logic [DW-1:0]   s1_a, s1_b;
    logic [IDW-1:0]  s1_id;
    logic [IDW-1:0]  rr_ptr, rr_nxt;
    logic [IDW:0]    nxt_w;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic [DW-1:0]   f_data;
    logic            f_err;

    assign adv2      = !s2_valid || rsp_ready;
    assign adv1      = !s1_valid || adv2;
    assign rsp_valid = s2_valid;
    assign req_ready = grant & {NREQ{adv1 & reset_n}};

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .gidx  (gidx)
    );

    assign nxt_w  = {1'b0, gidx} + (IDW+1)'(1);
    assign rr_nxt = (nxt_w == NREQ_W) ? '0 : nxt_w[IDW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_AND;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            rr_ptr   <= '0;
        end else if (adv1) begin
            s1_valid <= |grant;
            if (|grant) begin
                s1_op  <= bwu_op_t'(req_op[3*int'(gidx) +: 3]);
                s1_a   <= req_a[DW*int'(gidx) +: DW];
                s1_b   <= req_b[DW*int'(gidx) +: DW];
                s1_id  <= gidx;
                rr_ptr <= rr_nxt;
            end
        end
    end

    always_comb begin
        f_data = '0;
        f_err  = 1'b0;
        unique case (s1_op)
            OP_AND:  f_data = s1_a & s1_b;
            OP_OR:   f_data = s1_a | s1_b;
            OP_XOR:  f_data = s1_a ^ s1_b;
            OP_XNOR: f_data = s1_a ~^ s1_b;
            OP_NOT:  f_data = ~s1_a;
            OP_EQ:   f_data = {{(DW-1){1'b0}}, &(s1_a ~^ s1_b)};
            OP_RSV6,
            OP_RSV7: f_err  = 1'b1;
            default: f_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id   <= s1_id;
                rsp_data <= f_data;
                rsp_err  <= f_err;
            end
        end
    end

`ifdef BWU_PERF_CNT_EN
    logic [31:0] cnt [NREQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_valid[i] && cnt[i] != 32'hFFFF_FFFF) begin
                    cnt[i] <= cnt[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign grant_cnt[32*g +: 32] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// tb_bitwise_unit_arbiter: directed and random checks against a queue-based model.
// Honours BWU_PERF_CNT_EN for the grant counters.
module tb_bitwise_unit_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 64;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [3*NREQ-1:0]   req_op;
    logic [DW*NREQ-1:0]  req_a;
    logic [DW*NREQ-1:0]  req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_data;
    logic                rsp_err;
`ifdef BWU_PERF_CNT_EN
    logic [32*NREQ-1:0]  grant_cnt;
`endif

    always #5 clk = ~clk;

    bitwise_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
`ifdef BWU_PERF_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    typedef logic [66:0] rec_t;

    int   total = 0;
    int   bad   = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];
    int   arb_got_q[$];
    int   arb_exp_q[$];
    int   exp_rd = 0;
    int   obs_rd = 0;
    int   arb_rd = 0;
    int   mptr = 0;
    int   mcnt [NREQ];
    int   xfer_cnt = 0;
    int   multi_hot = 0;

    function automatic rec_t model(int id, logic [2:0] op,
                                   logic [63:0] a, logic [63:0] b);
        logic [63:0] d;
        logic        e;
        logic [1:0]  idb;
        d   = '0;
        e   = 1'b0;
        idb = id[1:0];
        case (op)
            3'd0: d = a & b;
            3'd1: d = a | b;
            3'd2: d = a ^ b;
            3'd3: d = ~(a ^ b);
            3'd4: d = ~a;
            3'd5: d = (a == b) ? 64'd1 : 64'd0;
            default: e = 1'b1;
        endcase
        return {e, idb, d};
    endfunction

    // Reference: expected winner is the first valid requester at or after mptr.
    always @(negedge clk) begin
        logic [NREQ-1:0] x;
        int w;
        int got;
        if (!reset_n) begin
            mptr = 0;
            for (int i = 0; i < NREQ; i++) mcnt[i] = 0;
        end else begin
            x = req_valid & req_ready;
            if ($countones(req_ready) > 1) multi_hot++;
            if (x != '0) begin
                w = -1;
                got = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && req_valid[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (got < 0 && x[i]) got = i;
                end
                arb_got_q.push_back(got);
                arb_exp_q.push_back(w);
                exp_q.push_back(model(got, req_op[got*3 +: 3],
                                      req_a[got*64 +: 64], req_b[got*64 +: 64]));
                mcnt[got]++;
                xfer_cnt++;
                mptr = (got + 1) % NREQ;
            end
            if (rsp_valid && rsp_ready) obs_q.push_back({rsp_err, rsp_id, rsp_data});
        end
    end

    task automatic sync_q();
        exp_rd = exp_q.size();
        obs_rd = obs_q.size();
        arb_rd = arb_got_q.size();
    endtask

    task automatic go_idle();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_op[i*3 +: 3] = 3'($urandom_range(0, 7));
            req_a[i*64 +: 64] = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) req_b[i*64 +: 64] = req_a[i*64 +: 64];
            else req_b[i*64 +: 64] = {$urandom, $urandom};
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(posedge clk);
            #1;
            if (obs_q.size() - obs_rd == exp_q.size() - exp_rd && !rsp_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        rand_ops();
        repeat (2) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
        total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
`ifdef BWU_PERF_CNT_EN
        total++; if (grant_cnt !== '0) begin bad++; $display("FAIL reset_grant_cnt got=%h exp=0", grant_cnt); end
`endif
        req_valid = '0;
        reset_n = 1'b1;
        go_idle();
        sync_q();
    endtask

    task automatic test_single();
        req_op[2:0] = 3'b011;
        req_a[63:0] = 64'h5555_5555_5555_5555;
        req_b[63:0] = 64'h5555_5555_5555_5555;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = '0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", rsp_valid); end
        @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
        total++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL single_data got=%h exp=ffffffffffffffff", rsp_data); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", rsp_err); end
        @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_dup got=%b exp=0", rsp_valid); end
        go_idle();
    endtask

    task automatic test_eq();
        for (int c = 0; c < 2; c++) begin
            req_op[5:3] = 3'b101;
            req_a[127:64] = 64'hAAAA_AAAA_AAAA_AAAA;
            req_b[127:64] = (c == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'hAAAA_AAAA_AAAA_AAAB;
            req_valid = 4'b0010;
            @(posedge clk);
            #1;
            req_valid = '0;
            @(posedge clk);
            #1;
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL eq_valid[%0d] got=%b exp=1", c, rsp_valid); end
            total++; if (rsp_data !== ((c == 0) ? 64'd1 : 64'd0)) begin bad++; $display("FAIL eq_data[%0d] got=%h exp=%0d", c, rsp_data, (c == 0) ? 1 : 0); end
            total++; if (rsp_id !== 2'd1) begin bad++; $display("FAIL eq_id[%0d] got=%0d exp=1", c, rsp_id); end
            go_idle();
        end
    endtask

    task automatic test_fairness();
        bit ok;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        sync_q();
        rand_ops();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) req_valid = '0;
            if (k == 1) begin
                total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL fair_early got=%b exp=0", rsp_valid); end
            end else begin
                total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 2) % 4)) begin
                    bad++; $display("FAIL fair_id[%0d] got=%b/%0d exp=1/%0d", k, rsp_valid, rsp_id, (k - 2) % 4);
                end
            end
        end
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL fair_drain got=timeout exp=drained"); end
        total++; if (exp_q.size() - exp_rd !== 6) begin bad++; $display("FAIL fair_count got=%0d exp=6", exp_q.size() - exp_rd); end
        while (obs_rd < obs_q.size() && exp_rd < exp_q.size()) begin
            total++; if (obs_q[obs_rd] !== exp_q[exp_rd]) begin bad++; $display("FAIL fair_rsp got=%h exp=%h", obs_q[obs_rd], exp_q[exp_rd]); end
            obs_rd++;
            exp_rd++;
        end
        sync_q();
    endtask

    task automatic test_backpressure();
        bit ok;
        int x0;
        logic [66:0] held;
        held = '0;
        sync_q();
        x0 = xfer_cnt;
        rand_ops();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) held = {rsp_err, rsp_id, rsp_data};
            if (k >= 2) begin
                total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL bp_ready[%0d] got=%h exp=0", k, req_ready); end
                total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, rsp_valid); end
            end
            if (k >= 3) begin
                total++; if ({rsp_err, rsp_id, rsp_data} !== held) begin bad++; $display("FAIL bp_stable[%0d] got=%h exp=%h", k, {rsp_err, rsp_id, rsp_data}, held); end
            end
        end
        total++; if (xfer_cnt - x0 !== 2) begin bad++; $display("FAIL bp_accepts got=%0d exp=2", xfer_cnt - x0); end
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_drain got=timeout exp=drained"); end
        total++; if (obs_q.size() - obs_rd !== xfer_cnt - x0) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size() - obs_rd, xfer_cnt - x0); end
        while (obs_rd < obs_q.size() && exp_rd < exp_q.size()) begin
            total++; if (obs_q[obs_rd] !== exp_q[exp_rd]) begin bad++; $display("FAIL bp_rsp got=%h exp=%h", obs_q[obs_rd], exp_q[exp_rd]); end
            obs_rd++;
            exp_rd++;
        end
        sync_q();
    endtask

    task automatic test_reserved();
        req_op[8:6] = 3'b111;
        req_a[191:128] = 64'hFFFF_FFFF_FFFF_FFFF;
        req_b[191:128] = 64'hFFFF_FFFF_FFFF_FFFF;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rsv_valid got=%b exp=1", rsp_valid); end
        total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL rsv_data got=%h exp=0", rsp_data); end
        total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL rsv_err got=%b exp=1", rsp_err); end
        total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL rsv_id got=%0d exp=2", rsp_id); end
        go_idle();
        sync_q();
    endtask

    task automatic test_random();
        bit ok;
        int mh0;
        mh0 = multi_hot;
        sync_q();
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL rand_drain got=timeout exp=drained"); end
        total++; if (obs_q.size() - obs_rd !== exp_q.size() - exp_rd) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size() - exp_rd); end
        while (obs_rd < obs_q.size() && exp_rd < exp_q.size()) begin
            total++; if (obs_q[obs_rd] !== exp_q[exp_rd]) begin bad++; $display("FAIL rand_rsp[%0d] got=%h exp=%h", obs_rd, obs_q[obs_rd], exp_q[exp_rd]); end
            obs_rd++;
            exp_rd++;
        end
        while (arb_rd < arb_got_q.size()) begin
            total++; if (arb_got_q[arb_rd] !== arb_exp_q[arb_rd]) begin bad++; $display("FAIL rand_grant[%0d] got=%0d exp=%0d", arb_rd, arb_got_q[arb_rd], arb_exp_q[arb_rd]); end
            arb_rd++;
        end
        total++; if (multi_hot !== mh0) begin bad++; $display("FAIL rand_onehot got=%0d exp=%0d", multi_hot, mh0); end
`ifdef BWU_PERF_CNT_EN
        for (int i = 0; i < NREQ; i++) begin
            total++; if (grant_cnt[i*32 +: 32] !== 32'(mcnt[i])) begin bad++; $display("FAIL rand_grant_cnt[%0d] got=%0d exp=%0d", i, grant_cnt[i*32 +: 32], mcnt[i]); end
        end
`endif
        sync_q();
    endtask

    task automatic test_reset_mid();
        rand_ops();
        rsp_ready = 1'b0;
        req_valid = 4'b1100;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_full got=%b exp=1", rsp_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL mid_req_ready got=%h exp=0", req_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        sync_q();
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
        @(posedge clk);
        #1;
        req_valid = '0;
`ifdef BWU_PERF_CNT_EN
        total++; if (grant_cnt !== {96'd0, 32'd1}) begin bad++; $display("FAIL mid_grant_cnt got=%h exp=1", grant_cnt); end
`endif
        @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin bad++; $display("FAIL mid_rsp got=%b/%0d exp=1/0", rsp_valid, rsp_id); end
        total++; if (exp_q.size() - exp_rd !== 1) begin bad++; $display("FAIL mid_xfers got=%0d exp=1", exp_q.size() - exp_rd); end
        else begin
            total++; if ({rsp_err, rsp_id, rsp_data} !== exp_q[exp_rd]) begin bad++; $display("FAIL mid_data got=%h exp=%h", {rsp_err, rsp_id, rsp_data}, exp_q[exp_rd]); end
        end
        go_idle();
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        test_reset();
        test_single();
        test_eq();
        test_fairness();
        test_backpressure();
        test_reserved();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
